// File: rtl/division_seq.sv
`default_nettype none
// ============================================================================
// Module   : division_seq
// Brief    : Sequential restoring divider, 2N-bit dividend / N-bit divisor,
//            one quotient bit per clock, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module division_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int              c_CW       = $clog2(2*N);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(2*N-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2*N-1:0]  r_dvd;
    logic [N-1:0]    r_dvs;
    logic [N-1:0]    r_prem;
    logic [c_CW-1:0] r_cnt;

    logic            w_accept;
    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N-1:0]    w_prem_nxt;
    logic [2*N-1:0]  w_dvd_nxt;

    // The partial remainder never reaches the divisor, so N stored bits
    // suffice; only the shifted trial value needs the extra bit.
    always_comb begin
        w_shift    = {r_prem, r_dvd[2*N-1]};
        w_ge       = (w_shift >= {1'b0, r_dvs});
        w_prem_nxt = w_ge ? (w_shift[N-1:0] - r_dvs) : w_shift[N-1:0];
        w_dvd_nxt  = {r_dvd[2*N-2:0], w_ge};
    end

    always_comb begin
        w_accept    = start && (r_state != S_CALC);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_cnt  <= c_CNT_INIT;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend[N-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (r_state == S_CALC) begin
            r_dvd  <= w_dvd_nxt;
            r_prem <= w_prem_nxt;
            r_cnt  <= r_cnt - c_CW'(1);
            if (r_cnt == '0) begin
                quotient    <= w_dvd_nxt;
                remainder   <= w_prem_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign ready = (r_state != S_CALC);
    assign busy  = (r_state == S_CALC);
    assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire
